// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA byte-stream adapter.
// Holds the operand width, the bytes per operand, the byte-counter width
// and the adapter state type.
package rsa_pkg;

    localparam int RSA_W     = 256;
    localparam int RSA_BYTES = 32;
    localparam int CNT_W     = $clog2(RSA_BYTES);

    typedef enum logic [2:0] {
        S_GET_N,
        S_GET_E,
        S_GET_A,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_CAP,
        S_SEND
    } adapter_state_t;

endpackage

// File: rtl/rsa_stream_adapter.sv
// Byte-stream front end for the 256-bit RSA exponentiation core.
// Collects modulus N, exponent E (once per reset) and message blocks A
// MSB-first from an 8-bit valid/ready stream, hands each block to the core,
// then returns the 256-bit result MSB-first on an 8-bit valid/ready stream.
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-low reset
//   i_in_data/i_in_valid/o_in_ready   input byte stream
//   o_out_data/o_out_valid/i_out_ready output byte stream
//   o_core_src_val/i_core_src_rdy     operand handshake to the core
//   o_core_a/o_core_e/o_core_n        operands to the core
//   i_core_result_val/o_core_result_rdy result handshake from the core
//   i_core_a_pow_e                    core result
module rsa_stream_adapter
    import rsa_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [7:0]       o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_core_src_val,
    input  logic             i_core_src_rdy,
    output logic [RSA_W-1:0] o_core_a,
    output logic [RSA_W-1:0] o_core_e,
    output logic [RSA_W-1:0] o_core_n,
    input  logic             i_core_result_val,
    output logic             o_core_result_rdy,
    input  logic [RSA_W-1:0] i_core_a_pow_e
);

    adapter_state_t   state;
    adapter_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [RSA_W-1:0] n_r;
    logic [RSA_W-1:0] e_r;
    logic [RSA_W-1:0] a_r;
    logic [RSA_W-1:0] out_r;

    logic in_fire;
    logic out_fire;
    logic last_byte;

    assign in_fire   = i_in_valid && o_in_ready;
    assign out_fire  = o_out_valid && i_out_ready;
    assign last_byte = (cnt == CNT_W'(RSA_BYTES - 1));

    // Operands go to the core straight from the shift registers; they only
    // move during the GET states, so they are stable while the core works.
    assign o_core_n   = n_r;
    assign o_core_e   = e_r;
    assign o_core_a   = a_r;
    assign o_out_data = out_r[RSA_W-1 -: 8];

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_GET_N;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block leaves a value unassigned (no latches).
    always_comb begin
        state_nxt         = state;
        o_in_ready        = 1'b0;
        o_out_valid       = 1'b0;
        o_core_src_val    = 1'b0;
        o_core_result_rdy = 1'b0;
        case (state)
            S_GET_N: begin
                o_in_ready = 1'b1;
                if (in_fire && last_byte) state_nxt = S_GET_E;
            end
            S_GET_E: begin
                o_in_ready = 1'b1;
                if (in_fire && last_byte) state_nxt = S_GET_A;
            end
            S_GET_A: begin
                o_in_ready = 1'b1;
                if (in_fire && last_byte) state_nxt = S_REQ;
            end
            S_REQ: begin
                o_core_src_val = 1'b1;
                if (i_core_src_rdy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_result_val) state_nxt = S_ACK;
            end
            S_ACK: begin
                // One-cycle acknowledge; the core updates its result on the
                // edge that ends this cycle, so capture waits for S_CAP.
                o_core_result_rdy = 1'b1;
                state_nxt         = S_CAP;
            end
            S_CAP: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                o_out_valid = 1'b1;
                // Key registers are kept: the next block only needs A.
                if (out_fire && last_byte) state_nxt = S_GET_A;
            end
            default: begin
                state_nxt = S_GET_N;
            end
        endcase
    end

    // Datapath: three input shift registers, the output shift register and
    // the shared byte counter. The counter wraps 31 -> 0 on the last byte of
    // each operand, which is exactly the restart value the next one needs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt   <= '0;
            n_r   <= '0;
            e_r   <= '0;
            a_r   <= '0;
            out_r <= '0;
        end else begin
            if (in_fire) begin
                cnt <= cnt + CNT_W'(1);
                case (state)
                    S_GET_N: n_r <= {n_r[RSA_W-9:0], i_in_data};
                    S_GET_E: e_r <= {e_r[RSA_W-9:0], i_in_data};
                    S_GET_A: a_r <= {a_r[RSA_W-9:0], i_in_data};
                    default: ;
                endcase
            end
            if (state == S_CAP) begin
                out_r <= i_core_a_pow_e;
                cnt   <= '0;
            end
            if (out_fire) begin
                out_r <= {out_r[RSA_W-9:0], 8'h00};
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
